// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and constants for the PCIe transmit arbiter.
package pcie_tx_arb_pkg;

  localparam int unsigned TUSER_W    = 4;
  localparam int unsigned PKT_CNT_W  = 32;
  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    CFG  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_picker #(
  parameter  int unsigned NUM_SRC = 3,
  localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan offsets 1..NUM_SRC from the last winner; keep the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      cand = IDX_W'((32'(last) + off) % NUM_SRC);
      if (req[cand] && !valid) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-level round-robin arbiter onto the PCIe core's AXI-Stream TX port.
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC    = 3,
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter  logic [5:0]  MIN_BUF_AV = 6'd2,
  localparam int unsigned IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                          user_clk,
  input  logic                          user_reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0] src_tkeep,
  input  logic [NUM_SRC*TUSER_W-1:0]    src_tuser,
  input  logic [NUM_SRC-1:0]            src_tlast,
  input  logic [NUM_SRC-1:0]            src_tvalid,
  output logic [NUM_SRC-1:0]            src_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [KEEP_WIDTH-1:0]         m_tkeep,
  output logic [TUSER_W-1:0]            m_tuser,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  input  logic [5:0]                    tx_buf_av,
  input  logic                          tx_cfg_req,
  output logic                          tx_cfg_gnt,
  input  logic                          tx_err_drop,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic [PKT_CNT_W-1:0]          pkt_count,
  output logic [DROP_CNT_W-1:0]         drop_count
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [PKT_CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic [DROP_CNT_W-1:0]  drop_count_q, drop_count_d;
  logic                   tx_cfg_gnt_q, tx_cfg_gnt_d;
  logic                   busy_q, busy_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   sel_tvalid;
  logic                   in_pkt;
  logic                   pkt_end;

  rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
    .req   (src_tvalid),
    .last  (last_grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Route the granted source to the core and the core's ready back to it.
  always_comb begin
    in_pkt     = (state_q == PKT);
    m_tdata    = '0;
    m_tkeep    = '0;
    m_tuser    = '0;
    m_tlast    = 1'b0;
    sel_tvalid = 1'b0;
    src_tready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        m_tdata       = src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep       = src_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_tuser       = src_tuser[i*TUSER_W +: TUSER_W];
        m_tlast       = src_tlast[i];
        sel_tvalid    = src_tvalid[i];
        src_tready[i] = in_pkt & m_tready;
      end
    end
    m_tvalid = in_pkt & sel_tvalid;
    pkt_end  = m_tvalid & m_tready & m_tlast;
  end

  // Next-state: config requests win in IDLE, grants hold until tlast.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    unique case (state_q)
      IDLE: begin
        if (tx_cfg_req) begin
          state_d = CFG;
        end else if (pick_valid && (tx_buf_av >= MIN_BUF_AV)) begin
          grant_id_d = pick_idx;
          state_d    = PKT;
        end
      end
      PKT: begin
        if (pkt_end) begin
          last_grant_d = grant_id_q;
          pkt_count_d  = pkt_count_q + PKT_CNT_W'(1);
          state_d      = IDLE;
        end
      end
      CFG: begin
        if (!tx_cfg_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tx_err_drop && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + DROP_CNT_W'(1);
    end
    tx_cfg_gnt_d = (state_d == CFG);
    busy_d       = (state_d == PKT);
  end

  // State and counter registers.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      tx_cfg_gnt_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      tx_cfg_gnt_q <= tx_cfg_gnt_d;
      busy_q       <= busy_d;
    end
  end

  assign grant_id   = grant_id_q;
  assign tx_cfg_gnt = tx_cfg_gnt_q;
  assign busy       = busy_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-level round-robin arbiter sharing the PCIe core's 64-bit AXI4-Stream transmit port (s_axis_tx_*) among NUM_SRC requesters, e.g. DMA read requests, completions and MSI writes. Grant is held for a whole TLP. New packets start only when core transmit buffer space allows. The block answers the core's configuration-transmit request (tx_cfg_req/tx_cfg_gnt) between packets. It sits in the user_clk_out domain between the TLP sources and the core wrapper.

## Interface
- NUM_SRC, 3: number of requesters, 2..8.
- DATA_WIDTH, 64: TLP data width.
- KEEP_WIDTH, DATA_WIDTH/8: byte-enable width.
- MIN_BUF_AV, 6'd2: minimum tx_buf_av required to start a packet.
- user_clk  in  1  core user clock; all logic is on the rising edge.
- user_reset  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- src_tdata  in  NUM_SRC*DATA_WIDTH  flattened per-source data, with source i at slice i.
- src_tkeep  in  NUM_SRC*KEEP_WIDTH  per-source byte enables.
- src_tuser  in  NUM_SRC*4  per-source tuser (discontinue, streaming, error-forward, ECRC-gen).
- src_tlast  in  NUM_SRC  per-source end of packet.
- src_tvalid  in  NUM_SRC  per-source valid.
- src_tready  out  NUM_SRC  per-source ready.
- m_tdata  out  DATA_WIDTH  to core s_axis_tx_tdata.
- m_tkeep  out  KEEP_WIDTH  to core s_axis_tx_tkeep.
- m_tuser  out  4  to core s_axis_tx_tuser.
- m_tlast  out  1  to core s_axis_tx_tlast.
- m_tvalid  out  1  to core s_axis_tx_tvalid.
- m_tready  in  1  from core s_axis_tx_tready.
- tx_buf_av  in  6  core transmit buffers available.
- tx_cfg_req  in  1  core wants to send a configuration TLP.
- tx_cfg_gnt  out  1  grant to the core for configuration transmit.
- tx_err_drop  in  1  core dropped a TLP (one-cycle pulse).
- grant_id  out  $clog2(NUM_SRC)  current/last granted source.
- busy  out  1  high while in PKT.
- pkt_count  out  32  total packets completed; wraps.
- drop_count  out  16  tx_err_drop pulses; saturates at 16'hFFFF.

## Operation
The state machine has three states: IDLE, PKT and CFG. Reset state is IDLE.

- **IDLE:**
  - If tx_cfg_req=1, go to CFG. Configuration requests take priority over new packets.
  - Else, if |src_tvalid and tx_buf_av >= MIN_BUF_AV, do the following:
    - Pick the first valid source searching from last_grant+1 upward, modulo NUM_SRC.
    - Register the pick into grant_id.
    - Go to PKT.
  - Else, stay in IDLE.
- **PKT:**
  - Data path: m_tdata/m_tkeep/m_tuser/m_tlast/m_tvalid = source grant_id's signals (combinational mux).
  - Ready path: src_tready[grant_id] = m_tready; all other src_tready are 0.
  - On a beat with m_tvalid & m_tready & m_tlast:
    - last_grant <= grant_id.
    - pkt_count += 1.
    - Go to IDLE.
  - tx_cfg_req is ignored until the packet ends.
  - tx_buf_av is not rechecked mid-packet.
- **CFG:**
  - tx_cfg_gnt=1 (registered).
  - All src_tready=0 and m_tvalid=0.
  - Return to IDLE on the cycle after tx_cfg_req is sampled 0.
- tx_cfg_gnt is 0 in IDLE and PKT.
- m_tvalid and all src_tready are 0 outside PKT.
- drop_count increments on each cycle tx_err_drop=1 (saturating), independent of state.

## Timing
- Reset values:
  - State = IDLE.
  - grant_id = 0.
  - last_grant = NUM_SRC-1, so source 0 wins first.
  - tx_cfg_gnt = 0, busy = 0.
  - src_tready = 0, m_tvalid = 0.
  - pkt_count = 0, drop_count = 0.
- Arbitration latency: the request is sampled in IDLE; the first beat can transfer on the next cycle.
- Mid-packet throughput is 1 beat/cycle. There is no added latency on data or ready.
- Each packet end costs one IDLE bubble cycle, so the back-to-back packet rate is N beats per N+1 cycles.
- A single-beat packet (tlast on its first beat) works the same way: PKT lasts one cycle when m_tready=1.
- Simultaneous events in IDLE: tx_cfg_req and src_tvalid both high → CFG wins. The source stays pending, and last_grant is unchanged.
- When src_tvalid is high but tx_buf_av < MIN_BUF_AV, the block stays in IDLE. No grant is issued and the round-robin pointer does not advance.
- The granted source must hold tvalid until tlast, per AXI-Stream rules. If tvalid drops mid-packet, m_tvalid drops with it and PKT continues.
- user_reset mid-packet: all outputs return to reset values immediately (asynchronously). The truncated TLP is the sources' responsibility.
- pkt_count wraps from 2^32-1 to 0.

## Structure
- Package pcie_tx_arb_pkg holds:
  - the state typedef (IDLE/PKT/CFG);
  - the TUSER_W=4 constant;
  - the counter widths (PKT_CNT_W=32, DROP_CNT_W=16).
- One sub-module, rr_picker: a combinational round-robin picker.
  - Inputs: req[NUM_SRC-1:0] and last[$clog2(NUM_SRC)-1:0].
  - Outputs: valid and idx.
  - The top level holds the FSM, the registers, the mux and the counters.

## Test plan
- Single source: source 1 sends a 3-beat TLP with m_tready=1.
  - Required: the beats appear on m_* on cycles 1–3 after the request.
  - Required: grant_id=1, pkt_count=1, then IDLE.
- Contention: all 3 sources are valid continuously with 2-beat packets.
  - Required grant order: 0,1,2,0,…
  - Required spacing: exactly one IDLE cycle between packets.
  - Required: pkt_count=6 after six packets.
- Config priority: tx_cfg_req rises during source 0's packet.
  - Required: tx_cfg_gnt=0 until tlast is accepted.
  - Required: tx_cfg_gnt=1 from the cycle after the IDLE cycle.
  - Required: after tx_cfg_req falls, source 2's pending packet follows.
- Buffer gating: tx_buf_av=1 with src_tvalid[0]=1.
  - Required: no grant for 10 cycles.
  - Then raise tx_buf_av to 2; required: the packet starts on the following cycle.
- Backpressure and drops:
  - m_tready toggles every cycle during a 4-beat packet. Required: src_tready mirrors m_tready and the data order is preserved.
  - Apply 3 tx_err_drop pulses. Required: drop_count=3.
  - Force drop_count to 16'hFFFF and apply one more pulse. Required: it stays at FFFF.
- Reset mid-packet: assert user_reset on beat 2 of 4.
  - Required: m_tvalid, src_tready and tx_cfg_gnt go to 0 without waiting for a clock edge.
  - Required: counters are 0.
  - Required: the first post-reset grant goes to source 0.
